// File: rtl/product_accumulator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : product_accumulator_if                                    |
// | Purpose  : Product-in / result-out handshake bundle for the          |
// |            product accumulator.                                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface product_accumulator_if #(
  parameter int N     = 5,
  parameter int COUNT = 4,
  parameter int ACC_W = 12,
  parameter int CW    = $clog2(COUNT + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   product;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CW-1:0]    out_count;
  logic             out_overflow;

  // Producer/consumer side: feeds products, takes results.
  modport master (
    output in_valid, product, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  // Accumulator side.
  modport slave (
    input  in_valid, product, flush, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );
endinterface
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : product_accumulator                                       |
// | Purpose  : Converts sign-magnitude products to two's complement and  |
// |            sums COUNT of them (or fewer on flush) into a saturating  |
// |            accumulator; presents each sum over a valid/ready port.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module product_accumulator #(
  parameter int N     = 5,
  parameter int COUNT = 4,
  parameter int ACC_W = 12,
  parameter int CW    = $clog2(COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  product_accumulator_if.slave bus
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CW-1:0]    c_count   = CW'(COUNT);

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [ACC_W-1:0] r_out_sum, w_out_sum_nxt;
  logic [CW-1:0]    r_out_count, w_out_count_nxt;
  logic             r_out_ovf, w_out_ovf_nxt;

  logic [ACC_W:0]   w_mag;
  logic [ACC_W:0]   w_term;
  logic [ACC_W:0]   w_sum;
  logic             w_sat;
  logic [ACC_W-1:0] w_acc_upd;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_accept;
  logic             w_close;

  // Term conversion and saturating add; one bit of headroom suffices because
  // |term| < 2^(2N-1) <= 2^(ACC_W-1), so an out-of-range sum shows up as a
  // disagreement between the two top bits. Negative zero negates to zero.
  always_comb begin
    w_mag     = {{(ACC_W+2-2*N){1'b0}}, bus.product[2*N-2:0]};
    w_term    = bus.product[2*N-1] ? -w_mag : w_mag;
    w_sum     = {r_acc[ACC_W-1], r_acc} + w_term;
    w_sat     = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    w_acc_upd = w_sat ? (w_sum[ACC_W] ? c_acc_min : c_acc_max) : w_sum[ACC_W-1:0];
    w_cnt_inc = r_cnt + CW'(1);
    w_accept  = bus.in_valid & (r_state == ST_ACCUM);
  end

  // Next-state and datapath decode; a closing cycle folds in any product
  // accepted on that same edge before the result is latched.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_out_sum_nxt   = r_out_sum;
    w_out_count_nxt = r_out_count;
    w_out_ovf_nxt   = r_out_ovf;
    w_close         = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        if (w_accept) begin
          w_acc_nxt = w_acc_upd;
          w_cnt_nxt = w_cnt_inc;
          w_ovf_nxt = r_ovf | w_sat;
        end
        w_close = (w_accept && (w_cnt_inc == c_count)) ||
                  (bus.flush && (w_accept || (r_cnt != '0)));
        if (w_close) begin
          w_out_sum_nxt   = w_acc_nxt;
          w_out_count_nxt = w_cnt_nxt;
          w_out_ovf_nxt   = w_ovf_nxt;
          w_state_nxt     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = ST_ACCUM;
        end
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  // State and datapath registers; reset discards any partial or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_sum   <= w_out_sum_nxt;
      r_out_count <= w_out_count_nxt;
      r_out_ovf   <= w_out_ovf_nxt;
    end
  end

  // Handshake flags come straight from the state register.
  assign bus.in_ready     = (r_state == ST_ACCUM);
  assign bus.out_valid    = (r_state == ST_HOLD);
  assign bus.out_sum      = r_out_sum;
  assign bus.out_count    = r_out_count;
  assign bus.out_overflow = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_product_accumulator                                    |
// | Purpose  : Scoreboard bench for product_accumulator; instance 0 uses |
// |            ACC_W=12, instance 1 uses ACC_W=10 for saturation.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_product_accumulator;
  localparam int COUNT = 4;

  typedef struct {
    int sum;
    int cnt;
    int ovf;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Edge counter used to check result latency.
  always @(posedge clk) cyc <= cyc + 1;

  product_accumulator_if #(.N(5), .COUNT(COUNT), .ACC_W(12)) ifa ();
  product_accumulator_if #(.N(5), .COUNT(COUNT), .ACC_W(10)) ifb ();

  product_accumulator #(.N(5), .COUNT(COUNT), .ACC_W(12)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  product_accumulator #(.N(5), .COUNT(COUNT), .ACC_W(10)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  logic       ival[2];
  logic       flsh[2];
  logic       ordy[2];
  logic [9:0] prod[2];
  logic       iready[2];
  logic       ovalid[2];
  int         osum[2];
  int         ocnt[2];
  logic       oovf[2];

  assign ifa.in_valid  = ival[0];
  assign ifa.flush     = flsh[0];
  assign ifa.out_ready = ordy[0];
  assign ifa.product   = prod[0];
  assign ifb.in_valid  = ival[1];
  assign ifb.flush     = flsh[1];
  assign ifb.out_ready = ordy[1];
  assign ifb.product   = prod[1];

  assign iready[0] = ifa.in_ready;
  assign ovalid[0] = ifa.out_valid;
  assign osum[0]   = int'($signed(ifa.out_sum));
  assign ocnt[0]   = int'(ifa.out_count);
  assign oovf[0]   = ifa.out_overflow;
  assign iready[1] = ifb.in_ready;
  assign ovalid[1] = ifb.out_valid;
  assign osum[1]   = int'($signed(ifb.out_sum));
  assign ocnt[1]   = int'(ifb.out_count);
  assign oovf[1]   = ifb.out_overflow;

  // Reference state: accepted terms of the open group, and expected results.
  int   pend[2][$];
  exp_t sbq[2][$];
  bit   prevv[2];

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, req);
    end
  endtask

  function automatic int term_of(input logic [9:0] p);
    int m;
    m = int'(p[8:0]);
    return p[9] ? -m : m;
  endfunction

  // Sum the open group with clamping after every term.
  function automatic exp_t model_result(input int d);
    exp_t r;
    int   hi;
    int   lo;
    int   acc;
    int   ovf;
    hi  = (d == 0) ? 2047 : 511;
    lo  = -hi - 1;
    acc = 0;
    ovf = 0;
    foreach (pend[d][i]) begin
      acc = acc + pend[d][i];
      if (acc > hi) begin acc = hi; ovf = 1; end
      if (acc < lo) begin acc = lo; ovf = 1; end
    end
    r.sum = acc;
    r.cnt = pend[d].size();
    r.ovf = ovf;
    r.cyc = 0;
    return r;
  endfunction

  // Present one beat on instance d; waits (bounded) while the DUT is in HOLD.
  task automatic send(input int d, input logic [9:0] p, input logic v,
                      input logic fl, input logic rdy);
    int   w;
    bit   acc_ok;
    exp_t e;
    w = 0;
    @(negedge clk);
    ival[1-d] = 1'b0;
    flsh[1-d] = 1'b0;
    ival[d]   = v;
    prod[d]   = p;
    flsh[d]   = fl;
    ordy[d]   = rdy;
    while (v && !iready[d] && w < 64) begin
      @(negedge clk);
      w++;
      if (w >= 8) ordy[d] = 1'b1;
    end
    if (v && !iready[d]) begin
      check("accept_timeout", 0, 1);
      ival[d] = 1'b0;
      flsh[d] = 1'b0;
      return;
    end
    acc_ok = v && iready[d];
    if (acc_ok) pend[d].push_back(term_of(p));
    if (iready[d] && ((acc_ok && pend[d].size() == COUNT) ||
                      (fl && pend[d].size() > 0))) begin
      e     = model_result(d);
      e.cyc = cyc + 1;
      sbq[d].push_back(e);
      pend[d].delete();
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        ival[d] = 1'b0;
        flsh[d] = 1'b0;
        ordy[d] = 1'b1;
      end
    end
  endtask

  // Monitor: compare every presented result cycle against the queue head.
  always @(negedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        prevv[d] = 1'b0;
      end else if (ovalid[d]) begin
        if (sbq[d].size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          check("out_sum", osum[d], sbq[d][0].sum);
          check("out_count", ocnt[d], sbq[d][0].cnt);
          check("out_overflow", int'(oovf[d]), sbq[d][0].ovf);
          check("in_ready_in_hold", int'(iready[d]), 0);
          if (!prevv[d]) check("result_latency", cyc, sbq[d][0].cyc);
          if (ordy[d]) void'(sbq[d].pop_front());
        end
        prevv[d] = ovalid[d] && !ordy[d];
      end else begin
        prevv[d] = 1'b0;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_out_valid"}, int'(ovalid[d]), 0);
      check({tag, "_out_sum"}, osum[d], 0);
      check({tag, "_out_count"}, ocnt[d], 0);
      check({tag, "_out_overflow"}, int'(oovf[d]), 0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      ival[d] = 1'b0;
      flsh[d] = 1'b0;
      ordy[d] = 1'b1;
      prod[d] = '0;
    end
    rst = 1'b1;
    #1;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", int'(iready[0]), 1);

    // Basic sum: -40 -33 +110 +0 = 37.
    send(0, 10'h228, 1, 0, 1);
    send(0, 10'h221, 1, 0, 1);
    send(0, 10'h06E, 1, 0, 1);
    send(0, 10'h000, 1, 0, 1);
    idle(3);

    // Backpressure: result held three cycles while the next product waits.
    send(0, 10'h011, 1, 0, 0);
    send(0, 10'h205, 1, 0, 0);
    send(0, 10'h033, 1, 0, 0);
    send(0, 10'h001, 1, 0, 0);
    fork
      send(0, 10'h00A, 1, 0, 0);
      begin
        repeat (4) @(negedge clk);
        ordy[0] = 1'b1;
      end
    join
    send(0, 10'h20B, 1, 0, 1);
    send(0, 10'h0FF, 1, 0, 1);
    send(0, 10'h1FF, 1, 0, 1);
    idle(3);

    // Flush with the product of the same cycle, then flush on an empty group.
    send(0, 10'h007, 1, 0, 1);
    send(0, 10'h005, 1, 1, 1);
    idle(3);
    send(0, 10'h000, 0, 1, 1);
    idle(3);

    // Negative zero.
    repeat (4) send(0, 10'h200, 1, 0, 1);
    idle(3);

    // Saturation on the narrow instance, then a clean group.
    send(1, 10'h100, 1, 0, 1);
    send(1, 10'h100, 1, 0, 1);
    send(1, 10'h300, 1, 0, 1);
    send(1, 10'h001, 1, 0, 1);
    send(1, 10'h003, 1, 0, 1);
    send(1, 10'h202, 1, 0, 1);
    send(1, 10'h005, 1, 0, 1);
    send(1, 10'h001, 1, 0, 1);
    idle(3);

    // Reset between edges mid-accumulation.
    send(0, 10'h050, 1, 0, 1);
    send(0, 10'h060, 1, 0, 1);
    idle(1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    for (int d = 0; d < 2; d++) begin
      pend[d].delete();
      sbq[d].delete();
    end
    @(negedge clk);
    rst = 1'b0;
    send(0, 10'h010, 1, 0, 1);
    send(0, 10'h220, 1, 0, 1);
    send(0, 10'h003, 1, 0, 1);
    send(0, 10'h004, 1, 0, 1);
    idle(3);

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      send(int'($urandom_range(0, 1)), 10'($urandom),
           logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 9) == 0),
           logic'($urandom_range(0, 2) != 0));
    end
    idle(1);
    for (int d = 0; d < 2; d++) begin
      if (pend[d].size() > 0) send(d, 10'h000, 0, 1, 1);
    end
    idle(20);
    check("drain_a", sbq[0].size(), 0);
    check("drain_b", sbq[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual %0d required %0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the signed multiplier. Accepts a stream of sign-magnitude products over a valid/ready handshake and converts each one to two's complement. It sums COUNT products, or fewer if flushed early, into a saturating accumulator, then presents the sum on an output valid/ready port. It provides the sequential dot-product stage behind the combinational multiplier.

## Interface
- N, 5, multiplier operand width; the product is 2N bits.
- COUNT, 4, number of products per result; at least 1.
- ACC_W, 12, accumulator and result width, two's complement; at least 2N.
- CW, $clog2(COUNT+1), derived width of the count fields.

Ports:
- clk  in  1  rising-edge clock; the block's one clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  product is present.
- in_ready  out  1  block can accept a product.
- product  in  2N  sign-magnitude: bit 2N-1 is the sign, bits 2N-2:0 are the unsigned magnitude.
- flush  in  1  close the current result early.
- out_valid  out  1  result is present.
- out_ready  in  1  consumer takes the result.
- out_sum  out  ACC_W  signed result.
- out_count  out  CW  number of products in out_sum.
- out_overflow  out  1  saturation occurred during this result.

## Operation
- States:
  - ACCUM: collecting products; in_ready=1.
  - HOLD: result presented; in_ready=0, out_valid=1.
- Internal state: acc[ACC_W-1:0], cnt[CW-1:0], sticky ovf.
- Term conversion:
  - mag = product[2N-2:0] zero-extended to ACC_W+1 bits.
  - term = sign ? -mag : mag.
  - Negative zero (sign=1, mag=0) gives term 0.
- Add: s = sext(acc) + term, computed in ACC_W+1 bits.
  - s > 2^(ACC_W-1)-1: acc becomes the maximum positive value; ovf=1.
  - s < -2^(ACC_W-1): acc becomes the minimum negative value; ovf=1.
  - Otherwise acc = s.
  - After saturation, accumulation continues from the saturated value.
- ACCUM, accept (in_valid & in_ready):
  - acc and ovf update as above; cnt increments.
  - If the new cnt equals COUNT: out_sum, out_count and out_overflow load the updated values; go to HOLD.
- ACCUM, flush:
  - If flush=1 and (cnt>0 or accepting this cycle): the product accepted this cycle, if any, is included first. Then the result is loaded and the block goes to HOLD.
  - If flush=1 with cnt=0 and no accept: ignored.
- HOLD:
  - flush and in_valid are ignored.
  - On out_ready=1: acc=0, cnt=0, ovf=0; go to ACCUM.
- out_sum, out_count and out_overflow are registered. They stay stable throughout HOLD and keep their last values afterward; they are meaningful only while out_valid=1.

## Timing
- Reset, asserted asynchronously, independent of clk:
  - state=ACCUM, acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_overflow=0.
  - in_ready=1 once rst is low.
- in_ready and out_valid are decoded directly from the state register; no combinational path from any input.
- Latency: out_valid rises on the clock edge that accepts the COUNT-th product or samples the flush. The result is therefore visible one cycle after that accept.
- Result handshake: out_valid drops on the edge where out_ready=1 is sampled in HOLD.
- in_ready returns to 1 in the same cycle out_valid drops.
- Minimum result-to-result gap: 1 bubble cycle, the HOLD cycle.
- Throughput in ACCUM: one product per clock.
- Reset mid-accumulation discards the partial sum; no result is emitted.
- Reset during HOLD discards the pending result.

## Test plan
- Basic sum (N=5, COUNT=4, ACC_W=12). Stimulus: products -40 (10'h228), -33 (10'h221), +110 (10'h06E), +0 on consecutive cycles, out_ready=1. Required: out_valid=1 for exactly one cycle, starting one cycle after the 4th accept, with out_sum=37, out_count=4, out_overflow=0.
- Backpressure. Stimulus: out_ready=0 for 3 cycles after the result, in_valid held 1 with the next product. Required: in_ready=0 and out_sum stable for all 3 cycles; the product is not consumed until the cycle after out_ready=1 is sampled. The next result equals the sum of the next 4 products only.
- Flush. Stimulus: accept +7, then present +5 with flush=1 in the same cycle. Required: out_sum=12, out_count=2. Separately, flush with cnt=0 and in_valid=0 produces no out_valid.
- Negative zero. Stimulus: 4 products of 10'h200. Required: out_sum=0, out_overflow=0.
- Saturation (ACC_W=10). Stimulus: products +256, +256, -256, +1. Required: acc saturates to 511 after the 2nd product, then 255, then 256; result out_sum=256 with out_overflow=1. The next result, with no overflow, reports out_overflow=0.
- Reset mid-operation. Stimulus: accept 2 products, pulse rst between clock edges. Required: all outputs read 0 immediately. A following group of 4 products sums from 0 with out_count=4.
